sha1_padder: RTL and testbench
==============================

# sha1_padder

Front-end message formatter for the SHA-1 core `top`. It accepts a byte stream and applies FIPS 180-4 padding, inserting the 0x80 marker, zero fill and the 64-bit big-endian bit length. It issues each 512-bit block to the core with the correct start/use_prev_cv handshake and returns the final 160-bit digest. It is the initiator for the core's block interface and sits between the AXI-side byte FIFO and `top`.

## Interface
- `IV`, default 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0, initial chaining value driven on `cv`.
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: byte-stream valid.
- `in_ready` out 1: byte-stream ready; a transfer occurs when valid and ready are both high.
- `in_data` in 8: message byte.
- `in_last` in 1: final beat of the message.
- `in_empty` in 1: qualifies a last beat that carries no byte (zero-length message); only legal with `in_last`=1.
- `blk_data` out [15:0][31:0]: block to the core (`data_i`); byte 0 at bits [511:504].
- `cv` out 160: constant `IV`.
- `blk_start` out 1: one-cycle start pulse to the core.
- `use_prev_cv` out 1: 0 on the first block of a message, 1 on every later block.
- `core_busy` in 1: core `busy`.
- `core_out_valid` in 1: core `out_valid`; the core clears it when it accepts a start.
- `core_cv_next` in 160: core `cv_next`.
- `digest` out 160: final hash, held until the next digest.
- `digest_valid` out 1: one-cycle pulse when `digest` updates.

## Operation
- States: FILL, ISSUE, WAIT, PAD, DONE.
- **FILL** (`in_ready`=1)
  - Each accepted byte is written at byte index `idx`; `idx`++; 61-bit byte counter `len`++.
  - A non-last byte that fills index 63 -> ISSUE, with `final`=0.
  - Last beat -> PAD. An `in_empty` beat writes nothing and does not count.
- **PAD** (single cycle)
  - If `idx`<64, write 0x80 at `idx` and set `mark_done`.
  - Bytes `idx`+1..63 -> 0.
  - If `mark_done` and `idx`<=55, write {`len`,3'b000} to bytes 56..63 and set `final`=1.
  - Otherwise `final`=0 and `extra`=1.
  -> ISSUE.
- **ISSUE**: `blk_start`=1 for exactly one cycle -> WAIT.
- **WAIT**
  - Completion is the first cycle with `core_busy`=0 and `core_out_valid`=1.
  - On completion, `use_prev_cv` <= 1, the block buffer clears and `idx` <= 0.
  - If `final`: capture `core_cv_next` into `digest`, then -> DONE.
  - Else if `extra`: -> PAD. The extra block takes 0x80 at byte 0 if `mark_done` is clear; the length always goes in bytes 56..63; `final`=1.
  - Else: -> FILL.
- **DONE**: `digest_valid`=1 for one cycle; `use_prev_cv`, `len` and all flags clear -> FILL.
- Every emitted block equals the FIPS padding of the message. The length field wraps modulo 2^64 bits.
- `blk_data` and `use_prev_cv` are stable from ISSUE until WAIT completes.

## Timing
- Reset values:
  - Outputs: `in_ready`=0 while `rstn` is low, 1 in FILL after release; `blk_start`=0, `use_prev_cv`=0, `digest_valid`=0, `digest`=0, `blk_data`=0.
  - Internal: state=FILL, `len`=0, `idx`=0.
- Reset asserted mid-message or mid-WAIT aborts immediately. The padder does not re-issue to the core; the core is reset by the same `rstn`.
- Byte throughput is 1 per cycle in FILL. `in_ready` drops in the cycle after the byte that fills a block or after `in_last`.
- Last-byte acceptance to `blk_start` is 2 cycles (PAD, ISSUE). Block-fill to `blk_start` is 1 cycle.
- Core completion to the next `blk_start` is 2 cycles for an extra pad block. Completion of the final block to `digest_valid` is 1 cycle.
- `in_valid` low in FILL stalls the padder with no state change. A stall may last indefinitely.
- Boundary cases:
  - 55 bytes in the last block -> single pad block.
  - 56–63 bytes -> extra block, zeros plus length.
  - 64 bytes -> extra block starting 0x80.

## Structure
- Package `sha1_pkg`: `IV` constant, `block_t` ([15:0][31:0]), `state_e` enum, and a byte-index helper for big-endian placement.
- No sub-module. FSM, byte buffer and length counter are one module.

## Test plan
- "abc" + `in_last` -> one block {"abc",0x80,0…,len=0x18}, `use_prev_cv`=0; `digest`=a9993e364706816aba3e25717850c26c9cd0d89d.
- 56-byte "abcdbcdecdef…nopq" -> two blocks, second block `use_prev_cv`=1 with bytes 0..55 zero and len=0x1C0; `digest`=84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- Empty message (`in_empty`,`in_last`) -> one block 0x80,0…,len=0; `digest`=da39a3ee5e6b4b0d3255bfef95601890afd80709.
- 55-byte and 64-byte messages -> 1 and 2 blocks respectively. For 64 bytes, the second block has byte 0=0x80 and len=0x200.
- Random `in_valid` gaps and a core model with variable busy length (1–90 cycles) -> digests identical to the gap-free runs, and exactly one `blk_start` per block.
- `rstn` pulsed mid-WAIT -> all outputs at reset values; the next "abc" gives a correct digest with `use_prev_cv`=0.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder.
//   IV        : SHA-1 initial chaining value (H0..H4, H0 in the top word)
//   block_t   : one 512-bit message block as 16 big-endian 32-bit words
//   state_e   : padder FSM states
//   byte_lsb  : bit offset of message byte n inside a flat 512-bit block
package sha1_pkg;

  localparam logic [159:0] IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

  typedef logic [15:0][31:0] block_t;

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_PAD   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Byte 0 sits at bits [511:504], byte 63 at bits [7:0].
  function automatic logic [8:0] byte_lsb(input logic [5:0] idx);
    return 9'd504 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/sha1_padder_if.sv
// Byte-stream interface feeding the SHA-1 padder.
//   in_valid / in_ready : handshake, a beat transfers when both are high
//   in_data             : message byte
//   in_last             : final beat of a message
//   in_empty            : last beat carries no byte (zero-length message)
// master = byte source (FIFO side), slave = padder.
interface sha1_padder_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_empty;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output in_empty,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  in_empty,
    output in_ready
  );

endinterface

// File: rtl/sha1_padder.sv
// SHA-1 message padder: collects a byte stream into 512-bit blocks, appends
// the 0x80 marker, zero fill and the 64-bit big-endian bit length, issues
// each block to the SHA-1 core and returns the final digest.
// Ports:
//   clk, rstn        : clock (rising edge), asynchronous active-low reset
//   bs               : byte-stream slave (valid/ready/data/last/empty)
//   blk_data         : block to the core, byte 0 at bits [511:504]
//   cv               : initial chaining value (constant IV)
//   blk_start        : one-cycle start pulse to the core
//   use_prev_cv      : 0 for the first block of a message, 1 afterwards
//   core_busy        : core busy flag
//   core_out_valid   : core result valid (cleared by the core on start)
//   core_cv_next     : core chaining value result
//   digest           : final hash, held until the next message completes
//   digest_valid     : one-cycle pulse when digest updates
module sha1_padder
  import sha1_pkg::*;
#(
  parameter logic [159:0] IV = sha1_pkg::IV
) (
  input  logic          clk,
  input  logic          rstn,
  sha1_padder_if.slave  bs,
  output block_t        blk_data,
  output logic [159:0]  cv,
  output logic          blk_start,
  output logic          use_prev_cv,
  input  logic          core_busy,
  input  logic          core_out_valid,
  input  logic [159:0]  core_cv_next,
  output logic [159:0]  digest,
  output logic          digest_valid
);

  state_e        state_q, state_d;
  logic [6:0]    idx_q, idx_d;        // next free byte slot, 64 = block full
  logic [60:0]   len_q, len_d;        // message length in bytes
  logic [511:0]  buf_q, buf_d;
  logic          final_q, final_d;    // block in flight is the last one
  logic          extra_q, extra_d;    // another pad block must follow
  logic          mark_q, mark_d;      // 0x80 marker already placed
  logic          use_prev_q, use_prev_d;
  logic [159:0]  digest_q, digest_d;
  logic          in_ready_q;
  logic          blk_start_q;
  logic          digest_valid_q;
  logic          fire_s;
  logic          done_s;

  assign fire_s = bs.in_valid && in_ready_q;
  assign done_s = !core_busy && core_out_valid;

  // Next-state, buffer and counter update for the padder FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    buf_d      = buf_q;
    final_d    = final_q;
    extra_d    = extra_q;
    mark_d     = mark_q;
    use_prev_d = use_prev_q;
    digest_d   = digest_q;
    case (state_q)
      S_FILL: begin
        if (fire_s) begin
          if (!bs.in_empty) begin
            buf_d[byte_lsb(idx_q[5:0]) +: 8] = bs.in_data;
            idx_d = idx_q + 7'd1;
            len_d = len_q + 61'd1;
          end else begin
            idx_d = idx_q;
          end
          if (bs.in_last) begin
            state_d = S_PAD;
          end else if (!bs.in_empty && (idx_q == 7'd63)) begin
            state_d = S_ISSUE;
            final_d = 1'b0;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_PAD: begin
        // The marker goes in only once per message; on an extra block with
        // the marker already placed, byte 0 simply stays zero.
        for (int unsigned i = 0; i < 64; i++) begin
          if (!mark_q && (idx_q < 7'd64) && (7'(i) == idx_q)) begin
            buf_d[byte_lsb(6'(i)) +: 8] = 8'h80;
          end else if (7'(i) > idx_q) begin
            buf_d[byte_lsb(6'(i)) +: 8] = 8'h00;
          end else begin
            buf_d[byte_lsb(6'(i)) +: 8] = buf_q[byte_lsb(6'(i)) +: 8];
          end
        end
        mark_d = mark_q || (idx_q < 7'd64);
        if (mark_d && (idx_q <= 7'd55)) begin
          buf_d[63:0] = {len_q, 3'b000};
          final_d     = 1'b1;
          extra_d     = 1'b0;
        end else begin
          final_d     = 1'b0;
          extra_d     = 1'b1;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_s) begin
          use_prev_d = 1'b1;
          buf_d      = 512'd0;
          idx_d      = 7'd0;
          if (final_q) begin
            digest_d = core_cv_next;
            state_d  = S_DONE;
          end else if (extra_q) begin
            state_d  = S_PAD;
          end else begin
            state_d  = S_FILL;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        use_prev_d = 1'b0;
        len_d      = 61'd0;
        final_d    = 1'b0;
        extra_d    = 1'b0;
        mark_d     = 1'b0;
        state_d    = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and datapath registers; handshake outputs are registered from
  // the next state so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_FILL;
      idx_q          <= 7'd0;
      len_q          <= 61'd0;
      buf_q          <= 512'd0;
      final_q        <= 1'b0;
      extra_q        <= 1'b0;
      mark_q         <= 1'b0;
      use_prev_q     <= 1'b0;
      digest_q       <= 160'd0;
      in_ready_q     <= 1'b0;
      blk_start_q    <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      buf_q          <= buf_d;
      final_q        <= final_d;
      extra_q        <= extra_d;
      mark_q         <= mark_d;
      use_prev_q     <= use_prev_d;
      digest_q       <= digest_d;
      in_ready_q     <= (state_d == S_FILL);
      blk_start_q    <= (state_d == S_ISSUE);
      digest_valid_q <= (state_d == S_DONE);
    end
  end

  assign bs.in_ready   = in_ready_q;
  assign blk_data      = buf_q;
  assign cv            = IV;
  assign blk_start     = blk_start_q;
  assign use_prev_cv   = use_prev_q;
  assign digest        = digest_q;
  assign digest_valid  = digest_valid_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: table of messages with hand-derived
// block counts and known digests, a behavioural SHA-1 core, cycle-timing
// checks and a reset-during-WAIT sequence.
module tb_sha1_padder;
  import sha1_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sha1_padder_if bif ();
  block_t        blk_data;
  logic [159:0]  cv, core_cv_next, digest;
  logic          blk_start, use_prev_cv, core_busy, core_out_valid, digest_valid;

  sha1_padder #(.IV(IV)) dut (
    .clk(clk), .rstn(rstn), .bs(bif),
    .blk_data(blk_data), .cv(cv), .blk_start(blk_start), .use_prev_cv(use_prev_cv),
    .core_busy(core_busy), .core_out_valid(core_out_valid), .core_cv_next(core_cv_next),
    .digest(digest), .digest_valid(digest_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_core = 1'b0;
  int busy_fix = 3;

  function automatic logic [159:0] sha1_f(input logic [159:0] h, input logic [511:0] m);
    logic [31:0] w [0:79];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {tmp[30:0], tmp[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Behavioural SHA-1 core with a configurable busy time.
  logic [159:0] pend;
  int           cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_busy <= 1'b0; core_out_valid <= 1'b0; core_cv_next <= 160'd0; cnt <= 0; pend <= 160'd0;
    end else if (blk_start) begin
      core_busy      <= 1'b1;
      core_out_valid <= 1'b0;
      cnt            <= rnd_core ? int'($urandom_range(90, 1)) : busy_fix;
      pend           <= sha1_f(use_prev_cv ? core_cv_next : cv, blk_data);
    end else if (core_busy) begin
      if (cnt <= 1) begin
        core_busy <= 1'b0; core_out_valid <= 1'b1; core_cv_next <= pend;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observation of issued blocks, completions, digests and byte transfers.
  logic [511:0] cap_blk [0:127];
  bit           cap_upc [0:127];
  int           cap_cyc [0:127];
  int           comp_cyc [0:127];
  int           cap_n = 0;
  bit           waiting = 1'b0;
  logic [159:0] dig_v;
  int           dig_n = 0;
  int           dig_cyc = 0;
  int           acc_cyc [0:511];
  int           acc_n = 0;
  always @(negedge clk) begin
    if (blk_start) begin
      cap_blk[cap_n % 128] <= blk_data;
      cap_upc[cap_n % 128] <= use_prev_cv;
      cap_cyc[cap_n % 128] <= cyc;
      cap_n   <= cap_n + 1;
      waiting <= 1'b1;
    end else if (waiting && !core_busy && core_out_valid) begin
      comp_cyc[(cap_n - 1) % 128] <= cyc;
      waiting <= 1'b0;
    end
    if (digest_valid) begin
      dig_v <= digest; dig_cyc <= cyc; dig_n <= dig_n + 1;
    end
    if (bif.in_valid && bif.in_ready) begin
      acc_cyc[acc_n % 512] <= cyc;
      acc_n <= acc_n + 1;
    end
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int           mode;   // 0 "abc", 1 56-char text, 2 empty, 3 byte pattern
    int           len;
    int           nblk;
    logic [159:0] dig;
    bit           chk_dig;
  } vec_t;
  vec_t vt [0:8];
  logic [159:0] dig0 [0:8];
  logic [7:0]   msg   [0:255];
  logic [7:0]   ref_b [0:255];

  task automatic load_msg(input int mode, input int len);
    string s;
    if (mode == 0) s = "abc";
    else if (mode == 1) s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    else s = "";
    for (int i = 0; i < len; i++) begin
      if (mode < 2) msg[i] = s[i];
      else msg[i] = 8'((i * 7 + 1) % 256);
    end
  endtask

  task automatic beat(input logic [7:0] d, input bit last, input bit empty, input bit gaps, output bit ok);
    int t;
    if (gaps && ($urandom_range(2, 0) == 0)) begin
      bif.in_valid = 1'b0; bif.in_data = 8'($urandom);
      repeat ($urandom_range(4, 1)) @(posedge clk);
      #1;
    end
    bif.in_valid = 1'b1; bif.in_data = d; bif.in_last = last; bif.in_empty = empty;
    ok = 1'b0; t = 0;
    while (!ok && t < 3000) begin
      if (bif.in_ready) ok = 1'b1;
      @(posedge clk); #1; t++;
    end
    bif.in_valid = 1'b0; bif.in_last = 1'b0; bif.in_empty = 1'b0;
  endtask

  task automatic run_msg(input int v, input bit gaps, output logic [159:0] got);
    int base, dbase, abase, nb, len, t, pidx, ncap;
    bit ok;
    logic [511:0] eb;
    logic [63:0]  lbits;
    logic [159:0] cvm;
    len = vt[v].len;
    load_msg(vt[v].mode, len);
    nb = (len + 8) / 64 + 1;
    for (int i = 0; i < nb * 64; i++) ref_b[i] = 8'h00;
    for (int i = 0; i < len; i++) ref_b[i] = msg[i];
    ref_b[len] = 8'h80;
    lbits = 64'(len) * 64'd8;
    for (int j = 0; j < 8; j++) ref_b[nb*64 - 8 + j] = lbits[63 - 8*j -: 8];
    base = cap_n; dbase = dig_n; abase = acc_n;
    rnd_core = gaps;
    ok = 1'b1;
    if (len == 0) begin
      beat(8'h00, 1'b1, 1'b1, gaps, ok);
    end else begin
      for (int i = 0; i < len && ok; i++) beat(msg[i], (i == len - 1), 1'b0, gaps, ok);
    end
    chk("accept_timeout", 512'(ok), 512'd1);
    t = 0;
    while (dig_n == dbase && t < 20000) begin @(posedge clk); #1; t++; end
    chk("digest_count", 512'(dig_n - dbase), 512'd1);
    repeat (4) @(posedge clk);
    #1;
    ncap = cap_n - base;
    chk("block_count", 512'(ncap), 512'(vt[v].nblk));
    cvm = IV;
    for (int k = 0; k < nb && k < ncap; k++) begin
      for (int j = 0; j < 64; j++) eb[511 - 8*j -: 8] = ref_b[k*64 + j];
      chk("block_data", cap_blk[(base + k) % 128], eb);
      chk("use_prev_cv", 512'(cap_upc[(base + k) % 128]), 512'(k > 0));
      cvm = sha1_f(cvm, eb);
    end
    chk("digest_model", 512'(dig_v), 512'(cvm));
    if (vt[v].chk_dig) chk("digest_known", 512'(dig_v), 512'(vt[v].dig));
    if (!gaps && ncap == nb) begin
      pidx = (len == 0) ? 0 : (len - 1) / 64;
      chk("lat_last_to_start",
          512'(cap_cyc[(base + pidx) % 128] - acc_cyc[(abase + (len == 0 ? 0 : len - 1)) % 512]), 512'd2);
      if (nb > pidx + 1)
        chk("lat_comp_to_extra",
            512'(cap_cyc[(base + pidx + 1) % 128] - comp_cyc[(base + pidx) % 128]), 512'd2);
      if (len > 64)
        chk("lat_fill_to_start", 512'(cap_cyc[base % 128] - acc_cyc[(abase + 63) % 512]), 512'd1);
      chk("lat_comp_to_digest", 512'(dig_cyc - comp_cyc[(base + nb - 1) % 128]), 512'd1);
    end
    got = dig_v;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] g;
    int base;
    int t;
    vt[0] = '{0,   3, 1, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b1};
    vt[1] = '{1,  56, 2, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 1'b1};
    vt[2] = '{2,   0, 1, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709, 1'b1};
    vt[3] = '{3,  55, 1, 160'd0, 1'b0};
    vt[4] = '{3,  64, 2, 160'd0, 1'b0};
    vt[5] = '{3,  63, 2, 160'd0, 1'b0};
    vt[6] = '{3, 119, 2, 160'd0, 1'b0};
    vt[7] = '{3, 120, 3, 160'd0, 1'b0};
    vt[8] = '{3, 128, 3, 160'd0, 1'b0};

    rstn = 1'b0;
    bif.in_valid = 1'b0; bif.in_data = 8'h00; bif.in_last = 1'b0; bif.in_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 512'(bif.in_ready), 512'd0);
    chk("rst_blk_start", 512'(blk_start), 512'd0);
    chk("rst_use_prev", 512'(use_prev_cv), 512'd0);
    chk("rst_digest_valid", 512'(digest_valid), 512'd0);
    chk("rst_digest", 512'(digest), 512'd0);
    chk("rst_blk_data", 512'(blk_data), 512'd0);
    chk("cv_iv", 512'(cv), 512'(160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0));
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_reset", 512'(bif.in_ready), 512'd1);

    for (int v = 0; v < 9; v++) begin
      run_msg(v, 1'b0, g);
      dig0[v] = g;
    end
    for (int v = 0; v < 9; v++) begin
      run_msg(v, 1'b1, g);
      chk("digest_gapfree", 512'(g), 512'(dig0[v]));
    end

    // Reset while the core is working on a block.
    rnd_core = 1'b0; busy_fix = 60;
    load_msg(0, 3);
    base = cap_n;
    fork
      begin
        bit ok;
        for (int i = 0; i < 3; i++) beat(msg[i], (i == 2), 1'b0, 1'b0, ok);
      end
    join
    t = 0;
    while (cap_n == base && t < 200) begin @(posedge clk); #1; t++; end
    chk("wait_issue", 512'(cap_n - base), 512'd1);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midwait_in_ready", 512'(bif.in_ready), 512'd0);
    chk("midwait_blk_start", 512'(blk_start), 512'd0);
    chk("midwait_use_prev", 512'(use_prev_cv), 512'd0);
    chk("midwait_digest_valid", 512'(digest_valid), 512'd0);
    chk("midwait_digest", 512'(digest), 512'd0);
    chk("midwait_blk_data", 512'(blk_data), 512'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    busy_fix = 3;
    @(posedge clk);
    #1;
    run_msg(0, 1'b0, g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
